// File: rtl/eq_pkg.sv
// Shared frame-timing constants and types for the audio codec interface.
package eq_pkg;

    localparam int unsigned FRAME_CNT_W = 10;
    localparam int unsigned SAMPLE_W    = 16;
    localparam int unsigned SCLK_BIT    = 4;
    localparam int unsigned MCLK_BIT    = 1;
    localparam int unsigned LRCLK_BIT   = 9;

    typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;
    typedef logic [SAMPLE_W-1:0]    sample_t;

    // Codec start-up: hold codec in reset for one frame, then let one full
    // frame run with the codec alive before any received data is trusted.
    typedef enum logic [1:0] {
        ST_CODEC_RST,
        ST_WARMUP,
        ST_RUN
    } startup_e;

endpackage

// File: rtl/codec_shift16.sv
// 16-bit loadable left-shift register, MSB-first; used for both the
// parallel-to-serial (tx) and serial-to-parallel (rx) sample paths.
module codec_shift16
    import eq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                shift,
    input  logic [SAMPLE_W-1:0] load_data,
    input  logic                ser_in,
    output logic [SAMPLE_W-1:0] par_out
);

    logic [SAMPLE_W-1:0] q;

    // Load has priority over shift; shifting pulls ser_in into the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {q[SAMPLE_W-2:0], ser_in};
        end
    end

    assign par_out = q;

endmodule

// File: rtl/codec_intf.sv
// Left-justified serial audio interface to a CS4272-style codec. All codec
// clocks are bits of one free-running frame counter, so they are glitch-free.
module codec_intf
    import eq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] lft_in,
    input  logic [SAMPLE_W-1:0] rht_in,
    output logic [SAMPLE_W-1:0] lft_out,
    output logic [SAMPLE_W-1:0] rht_out,
    output logic                valid,
    output logic                MCLK,
    output logic                SCLK,
    output logic                LRCLK,
    output logic                SDin,
    input  logic                SDout,
    output logic                RSTn
);

    frame_cnt_t          cnt;
    startup_e            state;
    logic                wrap;
    logic                half_end;
    logic                sclk_fall;
    logic                sclk_rise;
    logic                tx_load;
    logic [SAMPLE_W-1:0] tx_data;
    logic [SAMPLE_W-1:0] tx_q;
    logic [SAMPLE_W-1:0] rx_q;
    logic [SAMPLE_W-1:0] rht_buf;
    logic [SAMPLE_W-1:0] lft_rx;

    // Edge qualifiers are decoded from the current count, so the action
    // lands on the edge where the count reaches the named value.
    assign wrap      = (cnt == '1);
    assign half_end  = (cnt == frame_cnt_t'((1 << LRCLK_BIT) - 1));
    assign sclk_fall = (cnt[SCLK_BIT:0] == '1);
    assign sclk_rise = (cnt[SCLK_BIT:0] == {1'b0, {SCLK_BIT{1'b1}}});

    assign MCLK  = cnt[MCLK_BIT];
    assign SCLK  = cnt[SCLK_BIT];
    assign LRCLK = ~cnt[LRCLK_BIT];

    // Free-running frame counter, wraps every 1024 clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Right sample is parked at frame start until the left half has gone out;
    // the received left word is parked at mid-frame while the right shifts in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rht_buf <= '0;
            lft_rx  <= '0;
        end else begin
            if (wrap) begin
                rht_buf <= rht_in;
            end
            if (half_end) begin
                lft_rx <= rx_q;
            end
        end
    end

    // Left word loads at the frame wrap, right word at mid-frame; both are
    // SCLK falling edges, so SDin (the shifter MSB) only moves on those edges.
    assign tx_load = wrap | half_end;
    assign tx_data = wrap ? lft_in : rht_buf;
    assign SDin    = tx_q[SAMPLE_W-1];

    codec_shift16 u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tx_load),
        .shift     (sclk_fall),
        .load_data (tx_data),
        .ser_in    (1'b0),
        .par_out   (tx_q)
    );

    codec_shift16 u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (1'b0),
        .shift     (sclk_rise),
        .load_data ('0),
        .ser_in    (SDout),
        .par_out   (rx_q)
    );

    // Start-up sequencing, codec reset and the per-frame output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CODEC_RST;
            RSTn    <= 1'b0;
            valid   <= 1'b0;
            lft_out <= '0;
            rht_out <= '0;
        end else begin
            valid <= 1'b0;
            if (wrap) begin
                case (state)
                    ST_CODEC_RST: begin
                        state <= ST_WARMUP;
                        RSTn  <= 1'b1;
                    end
                    ST_WARMUP, ST_RUN: begin
                        state   <= ST_RUN;
                        valid   <= 1'b1;
                        lft_out <= lft_rx;
                        rht_out <= rx_q;
                    end
                    default: begin
                        state <= ST_CODEC_RST;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_codec_intf.sv
// Self-checking bench for codec_intf: frame-level behavioural model plus a
// simple codec model that serialises random samples onto SDout.
module tb_codec_intf;

    logic        clk;
    logic        rst_n;
    logic [15:0] lft_in;
    logic [15:0] rht_in;
    logic [15:0] lft_out;
    logic [15:0] rht_out;
    logic        valid;
    logic        MCLK;
    logic        SCLK;
    logic        LRCLK;
    logic        SDin;
    logic        SDout;
    logic        RSTn;

    logic        loop_mode;
    logic        drv_sd;

    assign SDout = loop_mode ? SDin : drv_sd;

    codec_intf dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .lft_in  (lft_in),
        .rht_in  (rht_in),
        .lft_out (lft_out),
        .rht_out (rht_out),
        .valid   (valid),
        .MCLK    (MCLK),
        .SCLK    (SCLK),
        .LRCLK   (LRCLK),
        .SDin    (SDin),
        .SDout   (SDout),
        .RSTn    (RSTn)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model state: k counts clk edges since reset release.
    int          k;
    logic [15:0] tx_l, tx_r;
    logic [15:0] rx_l, rx_r;
    logic [15:0] exp_lo, exp_ro;
    logic [15:0] snap_l, snap_r;
    logic        snap_sd;
    logic        prev_sdin;
    int          last_valid_k;

    // Codec model: per-frame analog-side samples.
    logic [15:0] aout_l, aout_r, done_l, done_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_MCLK"},    32'(MCLK),    32'd0);
        check({tag, "_SCLK"},    32'(SCLK),    32'd0);
        check({tag, "_LRCLK"},   32'(LRCLK),   32'd1);
        check({tag, "_SDin"},    32'(SDin),    32'd0);
        check({tag, "_RSTn"},    32'(RSTn),    32'd0);
        check({tag, "_valid"},   32'(valid),   32'd0);
        check({tag, "_lft_out"}, 32'(lft_out), 32'd0);
        check({tag, "_rht_out"}, 32'(rht_out), 32'd0);
    endtask

    task automatic model_reset();
        k            = 0;
        tx_l         = '0;
        tx_r         = '0;
        rx_l         = '0;
        rx_r         = '0;
        exp_lo       = '0;
        exp_ro       = '0;
        prev_sdin    = 1'b0;
        last_valid_k = -1;
    endtask

    // One clock: snapshot driven inputs, advance the model, compare all outputs.
    task automatic cycle();
        int          c;
        int          p;
        logic [15:0] w;
        logic        e_sdin;
        logic        e_valid;
        #1;
        snap_l  = lft_in;
        snap_r  = rht_in;
        snap_sd = SDout;
        @(posedge clk);
        #1;
        k++;
        c = k % 1024;
        p = (c % 512) / 32;
        e_valid = (k >= 2048) && (c == 0);
        if (c == 0) begin
            if (e_valid) begin
                exp_lo = rx_l;
                exp_ro = rx_r;
            end
            tx_l = snap_l;
            tx_r = snap_r;
        end
        if (c % 32 == 16) begin
            if (c < 512) rx_l[15-p] = snap_sd;
            else         rx_r[15-p] = snap_sd;
        end
        w      = (c < 512) ? tx_l : tx_r;
        e_sdin = (k < 1024) ? 1'b0 : w[15-p];

        check("MCLK",    32'(MCLK),    32'((c / 2) % 2));
        check("SCLK",    32'(SCLK),    32'((c / 16) % 2));
        check("LRCLK",   32'(LRCLK),   32'(c < 512));
        check("RSTn",    32'(RSTn),    32'(k >= 1024));
        check("SDin",    32'(SDin),    32'(e_sdin));
        check("valid",   32'(valid),   32'(e_valid));
        check("lft_out", 32'(lft_out), 32'(exp_lo));
        check("rht_out", 32'(rht_out), 32'(exp_ro));
        if (SDin !== prev_sdin) check("SDin_edge_phase", 32'(c % 32), 32'd0);
        prev_sdin = SDin;
        if (valid === 1'b1) begin
            if (last_valid_k >= 0) check("valid_gap", 32'(k - last_valid_k), 32'd1024);
            last_valid_k = k;
        end
        @(negedge clk);
    endtask

    task automatic codec_drive();
        int n;
        int p;
        n = (k + 1) % 1024;
        if (n == 0) begin
            done_l = aout_l;
            done_r = aout_r;
            aout_l = 16'($urandom);
            aout_r = 16'($urandom);
        end
        p = (n % 512) / 32;
        drv_sd = (n < 512) ? aout_l[15-p] : aout_r[15-p];
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        reset_checks(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        lft_in    = '0;
        rht_in    = '0;
        loop_mode = 1'b1;
        drv_sd    = 1'b0;
        aout_l    = '0;
        aout_r    = '0;
        done_l    = '0;
        done_r    = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_checks("init");
        rst_n = 1'b1;

        // Phase A: loopback, 8001 pattern, left input changed at cnt=512.
        rht_in = 16'h0F0F;
        for (int i = 0; i < 3072; i++) begin
            lft_in = (k >= 1535) ? 16'h7FFE : 16'h8001;
            cycle();
            if (k == 1023) check("A_RSTn_low",  32'(RSTn), 32'd0);
            if (k == 1024) check("A_RSTn_rise", 32'(RSTn), 32'd1);
            if (k == 1024) check("A_sdin_p0",   32'(SDin), 32'd1);
            if (k == 1056) check("A_sdin_p1",   32'(SDin), 32'd0);
            if (k == 1472) check("A_sdin_p14",  32'(SDin), 32'd0);
            if (k == 1504) check("A_sdin_p15",  32'(SDin), 32'd1);
            if (k == 1535) check("A_sdin_p15e", 32'(SDin), 32'd1);
            if (k == 1536) check("A_sdin_r0",   32'(SDin), 32'd0);
            if (k == 2047) check("A_no_valid",  32'(valid), 32'd0);
            if (k == 2048) check("A_valid1",    32'(valid), 32'd1);
            if (k == 2048) check("A_lft1",      32'(lft_out), 32'h8001);
            if (k == 2048) check("A_rht1",      32'(rht_out), 32'h0F0F);
            if (k == 2048) check("A_new_sdin0", 32'(SDin), 32'd0);
            if (k == 2080) check("A_new_sdin1", 32'(SDin), 32'd1);
            if (k == 3072) check("A_lft2",      32'(lft_out), 32'h7FFE);
        end

        // Phase B: loopback with held A5C3 / 1234.
        do_reset("rstB");
        lft_in = 16'hA5C3;
        rht_in = 16'h1234;
        for (int i = 0; i < 3072; i++) begin
            cycle();
            if (k == 3072) check("B_valid2", 32'(valid),   32'd1);
            if (k == 3072) check("B_lft2",   32'(lft_out), 32'hA5C3);
            if (k == 3072) check("B_rht2",   32'(rht_out), 32'h1234);
        end

        // Phase C: codec model on SDout, random inputs, reset at cnt=300.
        loop_mode = 1'b0;
        do_reset("rstC");
        while (k < 3 * 1024 + 300) begin
            lft_in = 16'($urandom);
            rht_in = 16'($urandom);
            codec_drive();
            cycle();
            if (k >= 2048 && k % 1024 == 0) begin
                check("C_codec_lft", 32'(lft_out), 32'(done_l));
                check("C_codec_rht", 32'(rht_out), 32'(done_r));
            end
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        reset_checks("midrst");
        @(posedge clk);
        #1;
        reset_checks("midrst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4 * 1024 + 10; i++) begin
            lft_in = 16'($urandom);
            rht_in = 16'($urandom);
            codec_drive();
            cycle();
            if (k == 2047) check("C_no_valid", 32'(valid), 32'd0);
            if (k == 2048) check("C_valid1",   32'(valid), 32'd1);
            if (k >= 2048 && k % 1024 == 0) begin
                check("C_codec_lft", 32'(lft_out), 32'(done_l));
                check("C_codec_rht", 32'(rht_out), 32'(done_r));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit (tests=%0d)", tests);
        $fatal(1, "timeout");
    end

endmodule
